// File: rtl/wb_pipe_reg_pkg.sv
// Shared definitions for the write-back pipeline register.
//   - Default GPR data and address widths.
//   - ZeroWord / NOPRegAddr: the all-zero word and the "no write" register address.
//   - occ_state_e: buffer occupancy state. Its encoding is the value seen on occ.
//   - wb_payload_t: one write-back record at the default widths, single channel.
package wb_pipe_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] ZeroWord   = '0;
  localparam logic [ADDR_W_DEF-1:0] NOPRegAddr = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] wd;
    logic                  wreg;
    logic [DATA_W_DEF-1:0] wdata;
    logic [DATA_W_DEF-1:0] hi;
    logic [DATA_W_DEF-1:0] lo;
    logic                  whilo;
  } wb_payload_t;

endpackage

// File: rtl/wb_pipe_slot.sv
// One payload register with a synchronous clear and a load enable.
// Clear has priority over load. A cleared slot holds all zeros, so it never
// presents a write.
//   clk : clock, rising edge
//   clr : synchronous clear to zero
//   ld  : load d on this edge
//   d   : payload in
//   q   : stored payload
module wb_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// Write-back pipeline register: a 2-entry in-order buffer between the memory
// stage and GPR/HI/LO write-back.
//
// Handshake: a transfer happens on an interface in any cycle where its valid
// and ready are both high at the rising clk edge. in_ready depends only on the
// occupancy register, so there is no combinational path from out_ready.
// out_valid is high while at least one entry is held.
//
// Ports:
//   clk, rst            : clock; synchronous active-high reset
//   flush               : drop every buffered entry and any same-cycle input
//   in_valid / in_ready : upstream handshake
//   in_wd, in_wreg, in_wdata : per-channel destination, write enable, data
//   in_hi, in_lo, in_whilo   : HI/LO write
//   out_valid / out_ready    : downstream handshake
//   out_*               : head entry. All zeros while out_valid is low.
//   occ                 : number of buffered entries (0..2). Also the FSM state.
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NCH     = 1,
  parameter int HILO_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*ADDR_W-1:0] in_wd,
  input  logic [NCH-1:0]        in_wreg,
  input  logic [NCH*DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0]     in_hi,
  input  logic [DATA_W-1:0]     in_lo,
  input  logic                  in_whilo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*ADDR_W-1:0] out_wd,
  output logic [NCH-1:0]        out_wreg,
  output logic [NCH*DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0]     out_hi,
  output logic [DATA_W-1:0]     out_lo,
  output logic                  out_whilo,
  output logic [1:0]            occ
);

  // Payload is carried as one flat vector. The HI/LO fields are only part of
  // it when the HI/LO path exists, so no HI/LO flops are built otherwise.
  localparam int CH_W = NCH * (ADDR_W + 1 + DATA_W);
  localparam int HL_W = (HILO_EN != 0) ? (2 * DATA_W + 1) : 0;
  localparam int PL_W = CH_W + HL_W;

  occ_state_e state_q, state_d;

  logic [PL_W-1:0] in_pl;
  logic [PL_W-1:0] head_d, head_q, skid_q;
  logic            head_ld, head_clr, skid_ld, skid_clr;
  logic            in_fire, out_fire;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occ       = state_q;

  assign in_fire   = in_valid  && in_ready;
  assign out_fire  = out_valid && out_ready;

  generate
    if (HILO_EN != 0) begin : g_hilo
      assign in_pl = {in_hi, in_lo, in_whilo, in_wd, in_wreg, in_wdata};
      assign {out_hi, out_lo, out_whilo, out_wd, out_wreg, out_wdata} = head_q;
    end else begin : g_no_hilo
      logic unused_hilo;
      assign unused_hilo = ^{in_hi, in_lo, in_whilo};
      assign in_pl       = {in_wd, in_wreg, in_wdata};
      assign {out_wd, out_wreg, out_wdata} = head_q;
      assign out_hi    = '0;
      assign out_lo    = '0;
      assign out_whilo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // The head slot always drives out_*. It is cleared whenever the buffer
  // empties, so a bubble shows all-zero outputs. The skid slot holds the
  // second entry. In FULL the head is refilled from the skid on a pop.
  always_comb begin
    state_d  = state_q;
    head_d   = in_pl;
    head_ld  = 1'b0;
    head_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          head_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          head_ld = 1'b1;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_d  = ST_EMPTY;
          head_clr = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d  = ST_ONE;
          head_d   = skid_q;
          head_ld  = 1'b1;
          skid_clr = 1'b1;
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        head_clr = 1'b1;
        skid_clr = 1'b1;
      end
    endcase
    // Flush overrides any same-cycle transfer. Clear wins over load in the slots.
    if (flush) begin
      state_d  = ST_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end
  end

  wb_pipe_slot #(.W(PL_W)) u_head (
    .clk (clk),
    .clr (rst || head_clr),
    .ld  (head_ld),
    .d   (head_d),
    .q   (head_q)
  );

  wb_pipe_slot #(.W(PL_W)) u_skid (
    .clk (clk),
    .clr (rst || skid_clr),
    .ld  (skid_ld),
    .d   (in_pl),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_wb_pipe_reg.sv
module tb_wb_pipe_reg;
  import wb_pipe_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT: defaults (NCH=1, HILO_EN=1)
  logic        flush, in_valid, in_ready, in_wreg, in_whilo;
  logic [4:0]  in_wd;
  logic [31:0] in_wdata, in_hi, in_lo;
  logic        out_valid, out_ready, out_wreg, out_whilo;
  logic [4:0]  out_wd;
  logic [31:0] out_wdata, out_hi, out_lo;
  logic [1:0]  occ;

  wb_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .out_hi(out_hi), .out_lo(out_lo), .out_whilo(out_whilo),
    .occ(occ)
  );

  // Two-channel DUT
  logic        m_in_valid, m_in_ready, m_in_whilo, m_out_valid, m_out_ready, m_out_whilo;
  logic [9:0]  m_in_wd, m_out_wd;
  logic [1:0]  m_in_wreg, m_out_wreg, m_occ_o;
  logic [63:0] m_in_wdata, m_out_wdata;
  logic [31:0] m_in_hi, m_in_lo, m_out_hi, m_out_lo;

  wb_pipe_reg #(.NCH(2), .HILO_EN(1)) dut_m (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_wd(m_in_wd), .in_wreg(m_in_wreg), .in_wdata(m_in_wdata),
    .in_hi(m_in_hi), .in_lo(m_in_lo), .in_whilo(m_in_whilo),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_wd(m_out_wd), .out_wreg(m_out_wreg), .out_wdata(m_out_wdata),
    .out_hi(m_out_hi), .out_lo(m_out_lo), .out_whilo(m_out_whilo),
    .occ(m_occ_o)
  );

  // HI/LO-disabled DUT
  logic        h_in_ready, h_out_valid, h_out_wreg, h_out_whilo;
  logic [4:0]  h_out_wd;
  logic [31:0] h_out_wdata, h_out_hi, h_out_lo;
  logic [1:0]  h_occ;

  wb_pipe_reg #(.HILO_EN(0)) dut_h (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(1'b1), .in_ready(h_in_ready),
    .in_wd(5'd7), .in_wreg(1'b1), .in_wdata(32'h1234_5678),
    .in_hi(32'hFFFF_FFFF), .in_lo(32'hFFFF_FFFF), .in_whilo(1'b1),
    .out_valid(h_out_valid), .out_ready(1'b1),
    .out_wd(h_out_wd), .out_wreg(h_out_wreg), .out_wdata(h_out_wdata),
    .out_hi(h_out_hi), .out_lo(h_out_lo), .out_whilo(h_out_whilo),
    .occ(h_occ)
  );

  // Scoreboard
  wb_payload_t exp_q[$];
  wb_payload_t in_pl, out_pl;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mdl_occ  = 0;
  logic        mon_en   = 1'b0;

  assign in_pl  = {in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo};
  assign out_pl = {out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo};

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model of the buffer, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      logic in_acc, out_acc;
      check_eq("occ", 128'(occ), 128'(mdl_occ));
      check_eq("in_ready", 128'(in_ready), 128'(mdl_occ != 2));
      check_eq("out_valid", 128'(out_valid), 128'(mdl_occ != 0));
      if (mdl_occ != 0) check_eq("head", 128'(out_pl), 128'(exp_q[0]));
      else              check_eq("bubble", 128'(out_pl), 128'(0));
      check_eq("h_whilo", 128'(h_out_whilo), 128'(0));
      check_eq("h_hilo", 128'({h_out_hi, h_out_lo}), 128'(0));
      in_acc  = in_valid && (mdl_occ != 2);
      out_acc = out_ready && (mdl_occ != 0);
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (out_acc) void'(exp_q.pop_front());
        if (in_acc)  exp_q.push_back(in_pl);
      end
      mdl_occ = exp_q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic [31:0] wdata, input logic rdy);
    in_valid  = v;
    in_wd     = wd;
    in_wreg   = v;
    in_wdata  = wdata;
    in_hi     = $urandom;
    in_lo     = $urandom;
    in_whilo  = 1'($urandom_range(0, 1));
    out_ready = rdy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    m_in_valid = 1'b0; m_in_wd = '0; m_in_wreg = '0; m_in_wdata = '0;
    m_in_hi = '0; m_in_lo = '0; m_in_whilo = 1'b0; m_out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    mon_en = 1'b1;
    check_eq("rst_occ", 128'(occ), 128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_out_wd", 128'(out_wd), 128'(NOPRegAddr));

    // Streaming: one beat per cycle, one-cycle latency, occ stays 1
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
      step();
      check_eq("stream_occ", 128'(occ), 128'(1));
      check_eq("stream_wdata", 128'(out_wdata), 128'(32'hDEAD_BEEF));
      check_eq("stream_wd", 128'(out_wd), 128'(3));
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    step();
    check_eq("stream_drain_occ", 128'(occ), 128'(0));

    // Backpressure: two entries, third push ignored, then in-order release
    drive(1'b1, 5'd4, 32'h11, 1'b0); step();
    drive(1'b1, 5'd5, 32'h22, 1'b0); step();
    check_eq("bp_occ_full", 128'(occ), 128'(2));
    check_eq("bp_in_ready", 128'(in_ready), 128'(0));
    drive(1'b1, 5'd6, 32'h33, 1'b0); step(); step();
    check_eq("bp_hold_occ", 128'(occ), 128'(2));
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check_eq("bp_first", 128'(out_wdata), 128'(32'h11));
    step();
    check_eq("bp_second", 128'(out_wdata), 128'(32'h22));
    step();
    check_eq("bp_empty", 128'(occ), 128'(0));

    // Flush with occ=2 and a same-cycle input
    drive(1'b1, 5'd7, 32'h44, 1'b0); step();
    drive(1'b1, 5'd8, 32'h55, 1'b0); step();
    check_eq("fl_occ_full", 128'(occ), 128'(2));
    drive(1'b1, 5'd9, 32'h66, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    check_eq("fl_occ", 128'(occ), 128'(0));
    check_eq("fl_out_valid", 128'(out_valid), 128'(0));
    check_eq("fl_out_wreg", 128'(out_wreg), 128'(0));
    step();
    check_eq("fl_dropped", 128'(occ), 128'(0));

    // Reset mid-stream with occ=2 and a pending handshake
    drive(1'b1, 5'd10, 32'h77, 1'b0); step();
    drive(1'b1, 5'd11, 32'h88, 1'b0); step();
    drive(1'b1, 5'd12, 32'h99, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    check_eq("rs_occ", 128'(occ), 128'(0));
    check_eq("rs_in_ready", 128'(in_ready), 128'(1));
    check_eq("rs_out_valid", 128'(out_valid), 128'(0));
    check_eq("rs_outputs", 128'(out_pl), 128'(0));

    // Two channels plus HI/LO in one beat
    m_in_valid = 1'b1; m_in_wd = {5'd2, 5'd1}; m_in_wreg = 2'b11;
    m_in_wdata = {32'hB, 32'hA}; m_in_hi = 32'h5; m_in_lo = 32'h6; m_in_whilo = 1'b1;
    step();
    m_in_valid = 1'b0;
    check_eq("mc_valid", 128'(m_out_valid), 128'(1));
    check_eq("mc_wd", 128'(m_out_wd), 128'({5'd2, 5'd1}));
    check_eq("mc_wreg", 128'(m_out_wreg), 128'(2'b11));
    check_eq("mc_wdata", 128'(m_out_wdata), 128'({32'hB, 32'hA}));
    check_eq("mc_hilo", 128'({m_out_hi, m_out_lo, m_out_whilo}), 128'({32'h5, 32'h6, 1'b1}));
    step();
    check_eq("mc_bubble", 128'({m_out_valid, m_out_wreg}), 128'(0));

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)));
      in_wreg = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    step(); step(); step();
    check_eq("final_occ", 128'(occ), 128'(0));

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
